// File: rtl/in_port_pkg.sv
// in_port_pkg: shared widths and parameter defaults for the switch input port.
package in_port_pkg;
  localparam int INPORT_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH_DEF = 4;
  localparam int DEBOUNCE_DEF = 16;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: synchronises a bouncy switch and emits its debounced level and rise pulse.
module sync_debounce
  import in_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s, done;
  assign s = sync[SYNC_STAGES-1];
  assign done = (s != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      cnt <= (s == level || done) ? '0 : cnt + 1'b1;
      level <= done ? s : level;
      rise <= done & s;
    end
endmodule

// File: rtl/in_port_producer.sv
// in_port_producer: debounced switch loads queued in a FIFO and presented to a CPU input port.
module in_port_producer
  import in_port_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        sw_data,
  input  logic                     sw_load,
  input  logic                     cpu_ack,
  output logic [INPORT_W-1:0]      inport,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [SYNC_STAGES-1:0][DATA_W-1:0] dsync;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic ack_q, rise, level, empty, full, pop_req, do_pop, do_push;
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk), .reset(reset), .d(sw_load), .level(level), .rise(rise)
  );
  assign empty = (count == '0);
  assign full = (count == (AW+1)'(DEPTH));
  assign pop_req = cpu_ack & ~ack_q;
  assign do_pop = pop_req & ~empty;
  assign do_push = rise & (~full | do_pop);
  assign inport = {~empty, empty ? {DATA_W{1'b0}} : mem[rp]};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dsync <= '0;
      ack_q <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      dsync <= {dsync[SYNC_STAGES-2:0], sw_data};
      ack_q <= cpu_ack;
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      overflow <= overflow | (rise & ~do_push);
    end
  // Storage is unreset: an entry is only visible once the tail has moved past it.
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= dsync[SYNC_STAGES-1];
endmodule
